// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Load hits return in the request cycle; misses refill one word over a req/ready port.
module dcache_ctrl #(
  parameter int SETS       = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [2:0]            cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic [2:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam logic [2:0] WE_LOAD = 3'b000;
  localparam logic [2:0] WE_SW   = 3'b001;
  localparam logic [2:0] WE_SB   = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [31:0]           data_q [SETS];
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_req_q;
  logic [2:0]            mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0] cpu_idx_s, lat_idx_s;
  logic [TAG_W-1:0] cpu_tag_s, lat_tag_s;
  logic cpu_hit_s, lat_hit_s, cpu_store_s;
  logic stall_s, capture_s, load_hit_s, load_miss_s, refill_s, store_upd_s;

  function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wdata,
                                              input logic [2:0] we, input logic [1:0] lane);
    logic [31:0] word;
    word = old_word;
    if (we == WE_SB) begin
      word[{lane, 3'b000} +: 8] = wdata[7:0];
    end else begin
      word = wdata;
    end
    return word;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    logic [CNT_WIDTH-1:0] res;
    if (cnt == {CNT_WIDTH{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // The latched memory address doubles as the in-flight request address.
  assign cpu_idx_s   = cpu_addr[2 +: IDX_W];
  assign cpu_tag_s   = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lat_idx_s   = mem_addr_q[2 +: IDX_W];
  assign lat_tag_s   = mem_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign cpu_hit_s   = valid_q[cpu_idx_s] && (tag_q[cpu_idx_s] == cpu_tag_s);
  assign lat_hit_s   = valid_q[lat_idx_s] && (tag_q[lat_idx_s] == lat_tag_s);
  assign cpu_store_s = (cpu_we == WE_SW) || (cpu_we == WE_SB);

  // Next-state, stall and load-data selection.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    stall_s     = 1'b0;
    capture_s   = 1'b0;
    load_hit_s  = 1'b0;
    load_miss_s = 1'b0;
    refill_s    = 1'b0;
    store_upd_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && cpu_store_s) begin
          stall_s   = 1'b1;
          capture_s = 1'b1;
          state_d   = S_WRITE;
        end else if (cpu_req && cpu_hit_s) begin
          rdata_d    = data_q[cpu_idx_s];
          load_hit_s = 1'b1;
        end else if (cpu_req) begin
          stall_s     = 1'b1;
          capture_s   = 1'b1;
          load_miss_s = 1'b1;
          state_d     = S_REFILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REFILL: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          refill_s = 1'b1;
          state_d  = S_RESP;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_RESP: begin
        rdata_d = data_q[lat_idx_s];
        state_d = S_IDLE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          store_upd_s = lat_hit_s;
          state_d     = S_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, valid bits, memory port registers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= {SETS{1'b0}};
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= WE_LOAD;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= 32'd0;
      hit_cnt_q   <= {CNT_WIDTH{1'b0}};
      miss_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      mem_req_q <= (state_d == S_REFILL) || (state_d == S_WRITE);
      if (capture_s) begin
        mem_we_q   <= cpu_store_s ? cpu_we : WE_LOAD;
        mem_addr_q <= cpu_store_s ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        if (cpu_store_s) begin
          mem_wdata_q <= cpu_wdata;
        end
      end else if (mem_req_q && mem_ready) begin
        mem_we_q <= WE_LOAD;
      end
      if (refill_s) begin
        valid_q[lat_idx_s] <= 1'b1;
      end
      if (load_hit_s) begin
        hit_cnt_q <= sat_inc(hit_cnt_q);
      end
      if (load_miss_s) begin
        miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

  // Tag/data arrays carry no reset; a reset cycle must still block any line update.
  always_ff @(posedge clk) begin
    if (!rst && refill_s) begin
      data_q[lat_idx_s] <= mem_rdata;
      tag_q[lat_idx_s]  <= lat_tag_s;
    end else if (!rst && store_upd_s) begin
      data_q[lat_idx_s] <= merge_store(data_q[lat_idx_s], mem_wdata_q, mem_we_q, mem_addr_q[1:0]);
    end
  end

  assign cpu_rdata  = rdata_d;
  assign cpu_stall  = stall_s;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a reference memory plus a small valid/tag model predict
// load data, stall length, memory transactions and counters.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [2:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic [2:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  dcache_ctrl #(.SETS(8), .ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [int];
  logic        mvalid [8];
  logic [26:0] mtag [8];
  int          exp_hit;
  int          exp_miss;
  txn_t        txn_q [$];
  logic [31:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int key;
    key = int'(a[31:2]);
    if (ref_mem.exists(key)) return ref_mem[key];
    return 32'hC0DE_0000 ^ {16'h0000, a[15:2], 2'b00};
  endfunction

  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [2:0] we,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (we == 3'b001) begin
      r = wd;
    end else begin
      case (lane)
        2'd0: r[7:0]   = wd[7:0];
        2'd1: r[15:8]  = wd[7:0];
        2'd2: r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  // One CPU access; waitc = cycles mem_req is high before the mem_ready strobe.
  task automatic access(input logic [2:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waitc);
    logic       is_store, hit, done;
    logic [2:0] idx;
    int         exp_stall, req_cnt, stall_cnt, cyc;
    txn_t       t, e;
    is_store = (we == 3'b001) || (we == 3'b011);
    idx      = addr[4:2];
    hit      = mvalid[idx] && (mtag[idx] == addr[31:5]);
    if (is_store) begin
      t = '{we, addr, wdata, 32'd0};
      txn_q.push_back(t);
      exp_stall = waitc + 1;
      ref_mem[int'(addr[31:2])] = apply_store(mem_word(addr), we, addr[1:0], wdata);
    end else begin
      rd_q.push_back(mem_word(addr));
      if (hit) begin
        exp_stall = 0;
        if (exp_hit < 15) exp_hit++;
      end else begin
        t = '{3'b000, {addr[31:2], 2'b00}, 32'd0, mem_word(addr)};
        txn_q.push_back(t);
        exp_stall = waitc + 2;
        if (exp_miss < 15) exp_miss++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = addr[31:5];
      end
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    req_cnt = 0; stall_cnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      mem_ready = 1'b0;
      if (mem_req === 1'b1) begin
        if (req_cnt == waitc) begin
          if (txn_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_req), 32'd0);
          end else begin
            e = txn_q.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            if (e.we != 3'b000) chk("mem_wdata", mem_wdata, e.wdata);
            mem_rdata = e.rdata;
          end
          mem_ready = 1'b1;
        end
        req_cnt++;
      end
      #4;
      if (cpu_stall === 1'b0) begin
        done = 1'b1;
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        if (!is_store) chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("access_timeout", 32'(done), 32'd1);
    mem_ready = 1'b0;
    cpu_req   = 1'b0;
    chk("mem_req_after", 32'(mem_req), 32'd0);
    chk("hit_count", 32'(hit_count), 32'(exp_hit));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    txn_q.delete();
    rd_q.delete();
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 3'b000; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);

    // 1: miss with 3 wait cycles, then a zero-latency hit
    ref_mem[4] = 32'hDEAD_BEEF;
    access(3'b000, 32'h10, 32'd0, 3);
    access(3'b000, 32'h10, 32'd0, 0);
    // 2: sw on a cached line, back-to-back load hit
    access(3'b001, 32'h10, 32'h1122_3344, 2);
    access(3'b000, 32'h10, 32'd0, 0);
    // 3: sb on a cached line, sb to an uncached line (no allocate)
    access(3'b011, 32'h12, 32'h0000_00AA, 1);
    access(3'b000, 32'h10, 32'd0, 0);
    access(3'b011, 32'h41, 32'h0000_0077, 0);
    access(3'b000, 32'h40, 32'd0, 2);
    // stray mem_ready while idle must be ignored
    mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    chk("stray_ready_req", 32'(mem_req), 32'd0);
    access(3'b000, 32'h40, 32'd0, 0);
    // 4: conflict eviction on index 1
    access(3'b000, 32'h04, 32'd0, 1);
    access(3'b000, 32'h24, 32'd0, 0);
    access(3'b000, 32'h04, 32'd0, 4);

    // 5: reset in REFILL with mem_ready in the same cycle
    cpu_req = 1'b1; cpu_we = 3'b000; cpu_addr = 32'h80; cpu_wdata = 32'd0;
    @(posedge clk); #1;
    chk("refill_req", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    chk("rst_refill_req", 32'(mem_req), 32'd0);
    chk("rst_refill_stall", 32'(cpu_stall), 32'd0);
    chk("rst_refill_hits", 32'(hit_count), 32'd0);
    chk("rst_refill_misses", 32'(miss_count), 32'd0);
    chk("rst_refill_rdata", cpu_rdata, 32'd0);
    model_reset();
    access(3'b000, 32'h10, 32'd0, 1);
    access(3'b000, 32'h80, 32'd0, 0);

    // 6: hit counter saturates at 4'hF
    for (int i = 0; i < 17; i++) access(3'b000, 32'h10, 32'd0, 0);
    chk("hit_saturated", 32'(hit_count), 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
